// File: rtl/carfield_preload_ctrl.sv
// Carfield preload controller.
// Arbitrates the boot-mode-eligible preload requester (JTAG, serial link or
// UART) onto a single downstream master port, and periodically polls the
// end-of-computation scratch register until it reports completion.
module carfield_preload_ctrl #(
  parameter int unsigned          AddrWidth  = 48,
  parameter int unsigned          DataWidth  = 32,
  parameter logic [AddrWidth-1:0] EocAddr    = 48'h0300_0008,
  parameter int unsigned          PollCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [1:0]             boot_mode_i,
  input  logic [1:0]             preload_mode_i,
  input  logic [2:0]             req_valid_i,
  output logic [2:0]             req_ready_o,
  input  logic [3*AddrWidth-1:0] req_addr_i,
  input  logic [2:0]             req_we_i,
  input  logic [3*DataWidth-1:0] req_wdata_i,
  output logic [2:0]             rsp_valid_o,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic                   rsp_err_o,
  output logic                   mst_req_o,
  output logic [AddrWidth-1:0]   mst_addr_o,
  output logic                   mst_we_o,
  output logic [DataWidth-1:0]   mst_wdata_o,
  input  logic                   mst_gnt_i,
  input  logic                   mst_rvalid_i,
  input  logic [DataWidth-1:0]   mst_rdata_i,
  input  logic                   mst_err_i,
  output logic                   eoc_o,
  output logic [DataWidth-2:0]   exit_code_o,
  output logic                   cfg_err_o
);

  localparam int unsigned          CntWidth = $clog2(PollCycles + 1);
  localparam logic [CntWidth-1:0]  CntMax   = CntWidth'(PollCycles);

  typedef enum logic [2:0] {
    LATCH,
    IDLE,
    REQ,
    RSP,
    POLL_REQ,
    POLL_RSP,
    DONE
  } state_e;

  state_e                state_q;
  logic [1:0]            boot_q;
  logic [1:0]            pre_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [1:0]            idx_q;

  logic [2:0]            elig;
  logic                  bad_cfg;
  logic [2:0]            hit;
  logic                  sel_valid;
  logic [1:0]            sel_idx;
  logic [AddrWidth-1:0]  sel_addr;
  logic                  sel_we;
  logic [DataWidth-1:0]  sel_wdata;
  logic                  rsp_take;
  logic                  poll_take;
  logic                  eoc_hit;
  logic [2:0]            idx_onehot;
  state_e                ret_state;

  // Requesters allowed to reach the master port under the latched modes.
  always_comb begin
    elig    = '0;
    bad_cfg = 1'b0;
    case (boot_q)
      2'd0: begin
        if (pre_q == 2'd3) bad_cfg = 1'b1;
        else               elig    = 3'(3'b001 << pre_q);
      end
      2'd1:    bad_cfg = 1'b1;
      default: elig    = 3'b001;
    endcase
  end

  // Pick the payload of the (at most one) eligible, valid requester.
  always_comb begin
    hit       = req_valid_i & elig;
    sel_valid = |hit;
    sel_idx   = '0;
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (hit[i]) begin
        sel_idx   = 2'(i);
        sel_addr  = req_addr_i[i*AddrWidth +: AddrWidth];
        sel_we    = req_we_i[i];
        sel_wdata = req_wdata_i[i*DataWidth +: DataWidth];
      end
    end
  end

  // Downstream response classification; rvalid in the grant cycle counts.
  always_comb begin
    rsp_take   = ((state_q == REQ && mst_gnt_i) || state_q == RSP) && mst_rvalid_i;
    poll_take  = ((state_q == POLL_REQ && mst_gnt_i) || state_q == POLL_RSP) && mst_rvalid_i;
    eoc_hit    = poll_take && mst_rdata_i[0] && !mst_err_i;
    idx_onehot = 3'(3'b001 << idx_q);
    ret_state  = eoc_o ? DONE : IDLE;
  end

  // Main controller: mode latch, arbitration, transaction and poll sequencing.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= LATCH;
      boot_q      <= '0;
      pre_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      req_ready_o <= '0;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      mst_req_o   <= 1'b0;
      mst_addr_o  <= '0;
      mst_we_o    <= 1'b0;
      mst_wdata_o <= '0;
      eoc_o       <= 1'b0;
      exit_code_o <= '0;
      cfg_err_o   <= 1'b0;
    end else begin
      req_ready_o <= '0;
      rsp_valid_o <= '0;

      if (state_q != LATCH && bad_cfg) cfg_err_o <= 1'b1;

      if (rsp_take) begin
        rsp_valid_o <= idx_onehot;
        rsp_rdata_o <= mst_rdata_i;
        rsp_err_o   <= mst_err_i;
      end

      if (eoc_hit) begin
        eoc_o       <= 1'b1;
        exit_code_o <= mst_rdata_i[DataWidth-1:1];
      end

      case (state_q)
        LATCH: begin
          boot_q  <= boot_mode_i;
          pre_q   <= preload_mode_i;
          state_q <= IDLE;
        end
        // DONE behaves like IDLE without the poll timer.
        IDLE, DONE: begin
          if (sel_valid) begin
            req_ready_o <= hit;
            idx_q       <= sel_idx;
            mst_req_o   <= 1'b1;
            mst_addr_o  <= sel_addr;
            mst_we_o    <= sel_we;
            mst_wdata_o <= sel_wdata;
            cnt_q       <= '0;
            state_q     <= REQ;
          end else if (state_q == IDLE) begin
            if (cnt_q == CntMax) begin
              mst_req_o   <= 1'b1;
              mst_addr_o  <= EocAddr;
              mst_we_o    <= 1'b0;
              mst_wdata_o <= '0;
              cnt_q       <= '0;
              state_q     <= POLL_REQ;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        REQ: begin
          if (mst_gnt_i) begin
            mst_req_o <= 1'b0;
            state_q   <= mst_rvalid_i ? ret_state : RSP;
          end
        end
        RSP: begin
          if (mst_rvalid_i) state_q <= ret_state;
        end
        POLL_REQ: begin
          if (mst_gnt_i) begin
            mst_req_o <= 1'b0;
            if (mst_rvalid_i) state_q <= eoc_hit ? DONE : IDLE;
            else              state_q <= POLL_RSP;
          end
        end
        POLL_RSP: begin
          if (mst_rvalid_i) state_q <= eoc_hit ? DONE : IDLE;
        end
        default: state_q <= LATCH;
      endcase
    end
  end

endmodule

// File: tb/tb_carfield_preload_ctrl.sv
// Self-checking bench for carfield_preload_ctrl: table of single-transaction
// vectors across boot/preload modes plus directed multi-cycle sequences.
module tb_carfield_preload_ctrl;

  localparam int          PC  = 4;
  localparam logic [47:0] EOC = 48'h0300_0008;

  logic         clk;
  logic         rst_n;
  logic [1:0]   boot_mode, pre_mode;
  logic [2:0]   req_valid, req_ready, req_we, rsp_valid;
  logic [143:0] req_addr;
  logic [95:0]  req_wdata;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic         mst_req, mst_we, mst_gnt, mst_rvalid, mst_err;
  logic [47:0]  mst_addr;
  logic [31:0]  mst_wdata, mst_rdata;
  logic         eoc;
  logic [30:0]  exit_code;
  logic         cfg_err;

  carfield_preload_ctrl #(.AddrWidth(48), .DataWidth(32), .EocAddr(EOC), .PollCycles(PC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .boot_mode_i(boot_mode), .preload_mode_i(pre_mode),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .mst_req_o(mst_req),
    .mst_addr_o(mst_addr), .mst_we_o(mst_we), .mst_wdata_o(mst_wdata),
    .mst_gnt_i(mst_gnt), .mst_rvalid_i(mst_rvalid), .mst_rdata_i(mst_rdata),
    .mst_err_i(mst_err), .eoc_o(eoc), .exit_code_o(exit_code), .cfg_err_o(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Downstream model controls (written by stimulus only)
  logic        model_en;
  int          gnt_delay;
  logic        same_cycle;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [31:0] poll_data0, poll_data1;
  int          poll_base;
  logic        man_gnt, man_rvalid;
  logic [31:0] man_rdata;

  // Monitor / model state (written by the model process only)
  int          cyc = 0;
  int          n_wr = 0, n_rd = 0, n_poll = 0, unstable = 0;
  int          ready_cnt[3];
  int          rsp_cnt[3];
  logic [31:0] rsp_last_data;
  logic        rsp_last_err;
  logic [47:0] last_wr_addr;
  logic [31:0] last_wr_data;
  int          gnt_cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_data;
  logic        pend_err;
  logic        prev_req = 1'b0;
  logic [47:0] prev_addr;
  logic [31:0] prev_wdata;

  initial begin
    for (int i = 0; i < 3; i++) begin
      ready_cnt[i] = 0;
      rsp_cnt[i]   = 0;
    end
  end

  // Monitor plus memory model: grants after gnt_delay request cycles, answers
  // polls from poll_data0/1 and other accesses from mem_rdata/mem_err.
  always @(negedge clk) begin
    logic [31:0] d;
    logic        e;
    int          k;
    cyc = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (req_ready[i]) ready_cnt[i] = ready_cnt[i] + 1;
      if (rsp_valid[i]) rsp_cnt[i]   = rsp_cnt[i] + 1;
    end
    if (|rsp_valid) begin
      rsp_last_data = rsp_rdata;
      rsp_last_err  = rsp_err;
    end
    if (mst_req && prev_req && (mst_addr != prev_addr || mst_wdata != prev_wdata))
      unstable = unstable + 1;
    prev_req   = mst_req;
    prev_addr  = mst_addr;
    prev_wdata = mst_wdata;

    mst_gnt    = 1'b0;
    mst_rvalid = 1'b0;
    mst_err    = 1'b0;
    if (!model_en) begin
      mst_gnt    = man_gnt;
      mst_rvalid = man_rvalid;
      mst_rdata  = man_rdata;
      gnt_cnt    = 0;
      pend       = 1'b0;
    end else if (!rst_n) begin
      gnt_cnt = 0;
      pend    = 1'b0;
    end else begin
      if (pend) begin
        mst_rvalid = 1'b1;
        mst_rdata  = pend_data;
        mst_err    = pend_err;
        pend       = 1'b0;
      end
      if (mst_req) begin
        if (gnt_cnt >= gnt_delay) begin
          mst_gnt = 1'b1;
          gnt_cnt = 0;
          if (!mst_we && mst_addr == EOC) begin
            k = n_poll - poll_base;
            d = (k == 0) ? poll_data0 : (k == 1) ? poll_data1 : 32'h0;
            e = 1'b0;
            n_poll = n_poll + 1;
          end else begin
            if (mst_we) begin
              n_wr = n_wr + 1;
              last_wr_addr = mst_addr;
              last_wr_data = mst_wdata;
            end else begin
              n_rd = n_rd + 1;
            end
            d = mem_rdata;
            e = mem_err;
          end
          if (same_cycle) begin
            mst_rvalid = 1'b1;
            mst_rdata  = d;
            mst_err    = e;
          end else begin
            pend      = 1'b1;
            pend_data = d;
            pend_err  = e;
          end
        end else begin
          gnt_cnt = gnt_cnt + 1;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset(input logic [1:0] b, input logic [1:0] p);
    rst_n     = 1'b0;
    req_valid = '0;
    step();
    step();
    boot_mode = b;
    pre_mode  = p;
    rst_n     = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ctl"}, 64'({req_ready, rsp_valid, rsp_err, mst_req, mst_we, eoc, cfg_err}), 64'h0);
    chk({tag, "_mst_addr"}, 64'(mst_addr), 64'h0);
    chk({tag, "_mst_wdata"}, 64'(mst_wdata), 64'h0);
    chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'h0);
    chk({tag, "_exit_code"}, 64'(exit_code), 64'h0);
  endtask

  function automatic int rsp_total();
    return rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2];
  endfunction

  typedef struct {
    logic [1:0]  boot;
    logic [1:0]  pre;
    logic [2:0]  mask;
    logic        we;
    logic [47:0] addr;
    logic [31:0] wdata;
    int          gd;
    logic        same;
    logic [31:0] mrd;
    logic        merr;
    logic [2:0]  exp;
    logic        exp_cfg;
    int          exp_wr;
    int          exp_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input int n);
    int          rdy0[3];
    int          rsp0[3];
    int          wr0, rd0, rt0;
    logic [2:0]  rdy_m, rsp_m;
    model_en   = 1'b1;
    gnt_delay  = v.gd;
    same_cycle = v.same;
    mem_rdata  = v.mrd;
    mem_err    = v.merr;
    apply_reset(v.boot, v.pre);
    for (int i = 0; i < 3; i++) begin
      rdy0[i] = ready_cnt[i];
      rsp0[i] = rsp_cnt[i];
    end
    wr0 = n_wr;
    rd0 = n_rd;
    rt0 = rsp_total();
    req_addr  = {3{v.addr}};
    req_we    = {3{v.we}};
    req_wdata = {3{v.wdata}};
    req_valid = v.mask;
    for (int c = 0; c < 30; c++) begin
      step();
      req_valid = req_valid & ~req_ready;
    end
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      rdy_m[i] = (ready_cnt[i] != rdy0[i]);
      rsp_m[i] = (rsp_cnt[i] != rsp0[i]);
    end
    chk($sformatf("v%0d_ready_mask", n), 64'(rdy_m), 64'(v.exp));
    chk($sformatf("v%0d_rsp_mask", n), 64'(rsp_m), 64'(v.exp));
    chk($sformatf("v%0d_rsp_count", n), 64'(rsp_total() - rt0), 64'($countones(v.exp)));
    chk($sformatf("v%0d_writes", n), 64'(n_wr - wr0), 64'(v.exp_wr));
    chk($sformatf("v%0d_reads", n), 64'(n_rd - rd0), 64'(v.exp_rd));
    chk($sformatf("v%0d_cfg_err", n), 64'(cfg_err), 64'(v.exp_cfg));
    if (v.exp != 3'b000) begin
      chk($sformatf("v%0d_rsp_rdata", n), 64'(rsp_last_data), 64'(v.mrd));
      chk($sformatf("v%0d_rsp_err", n), 64'(rsp_last_err), 64'(v.merr));
    end
    if (v.exp_wr != 0) begin
      chk($sformatf("v%0d_wr_addr", n), 64'(last_wr_addr), 64'(v.addr));
      chk($sformatf("v%0d_wr_data", n), 64'(last_wr_data), 64'(v.wdata));
    end
  endtask

  initial begin
    int p0, r0, g, unst0;
    bit seen;
    rst_n = 1'b0; boot_mode = '0; pre_mode = '0;
    req_valid = '0; req_addr = '0; req_we = '0; req_wdata = '0;
    model_en = 1'b1; gnt_delay = 0; same_cycle = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    poll_data0 = '0; poll_data1 = '0; poll_base = 0;
    man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = '0;

    //          boot  pre   mask    we    addr                 wdata          gd same mrd            merr  exp     cfg   wr rd
    vecs[0] = '{2'd0, 2'd1, 3'b111, 1'b1, 48'h0000_8000_0000, 32'hDEAD_BEEF, 3, 1'b0, 32'h0000_0000, 1'b0, 3'b010, 1'b0, 1, 0};
    vecs[1] = '{2'd0, 2'd0, 3'b111, 1'b0, 48'h0000_0000_1000, 32'h0,         0, 1'b1, 32'h1234_5678, 1'b0, 3'b001, 1'b0, 0, 1};
    vecs[2] = '{2'd0, 2'd2, 3'b100, 1'b0, 48'h0000_0000_2004, 32'h0,         1, 1'b0, 32'hCAFE_F00D, 1'b1, 3'b100, 1'b0, 0, 1};
    vecs[3] = '{2'd2, 2'd1, 3'b101, 1'b1, 48'h0000_0000_3000, 32'h0000_00A5, 2, 1'b0, 32'h0000_0000, 1'b0, 3'b001, 1'b0, 1, 0};
    vecs[4] = '{2'd3, 2'd2, 3'b110, 1'b1, 48'h0000_0000_4000, 32'h1111_1111, 0, 1'b0, 32'h0000_0000, 1'b0, 3'b000, 1'b0, 0, 0};
    vecs[5] = '{2'd1, 2'd0, 3'b111, 1'b1, 48'h0000_0000_5000, 32'h2222_2222, 0, 1'b0, 32'h0000_0000, 1'b0, 3'b000, 1'b1, 0, 0};
    vecs[6] = '{2'd0, 2'd3, 3'b111, 1'b1, 48'h0000_0000_6000, 32'h3333_3333, 0, 1'b0, 32'h0000_0000, 1'b0, 3'b000, 1'b1, 0, 0};
    vecs[7] = '{2'd0, 2'd1, 3'b101, 1'b0, 48'h0000_0000_7000, 32'h0,         0, 1'b0, 32'h0000_0000, 1'b0, 3'b000, 1'b0, 0, 0};

    step();
    step();
    check_reset("por");

    unst0 = unstable;
    for (int n = 0; n < 8; n++) run_vec(vecs[n], n);
    chk("payload_stable", 64'(unstable - unst0), 64'h0);

    // EOC polling: first poll reads 0, second reads 7 -> exit code 3.
    gnt_delay = 0; same_cycle = 1'b0; mem_rdata = 32'h0000_0042; mem_err = 1'b0;
    poll_data0 = 32'h0; poll_data1 = 32'h7;
    apply_reset(2'd0, 2'd0);
    poll_base = n_poll;
    for (int c = 0; c < 60 && !eoc; c++) step();
    chk("eoc_set", 64'(eoc), 64'h1);
    chk("eoc_exit_code", 64'(exit_code), 64'h3);
    chk("eoc_poll_count", 64'(n_poll - poll_base), 64'h2);
    for (int c = 0; c < 30; c++) step();
    chk("done_no_more_polls", 64'(n_poll - poll_base), 64'h2);
    r0 = rsp_cnt[0];
    req_addr = {3{48'h0000_0000_9000}}; req_we = '0; req_valid = 3'b001;
    for (int c = 0; c < 20; c++) begin
      step();
      req_valid = req_valid & ~req_ready;
    end
    req_valid = '0;
    chk("done_serviced", 64'(rsp_cnt[0] - r0), 64'h1);
    chk("done_rsp_rdata", 64'(rsp_last_data), 64'h42);
    chk("done_eoc_kept", 64'({eoc, exit_code}), 64'({1'b1, 31'h3}));
    chk("done_polls_after_req", 64'(n_poll - poll_base), 64'h2);
    poll_data1 = 32'h0;

    // Boot mode 1: cfg_err timing and polling continues.
    apply_reset(2'd1, 2'd0);
    step();
    chk("cfg_err_cycle1", 64'(cfg_err), 64'h0);
    step();
    chk("cfg_err_cycle2", 64'(cfg_err), 64'h1);
    p0 = n_poll;
    r0 = rsp_total();
    req_valid = 3'b111;
    for (int c = 0; c < 30; c++) step();
    req_valid = '0;
    chk("cfg_err_polls_continue", 64'(n_poll - p0 >= 2), 64'h1);
    chk("cfg_err_no_service", 64'(rsp_total() - r0), 64'h0);

    // Request arriving in the cycle the poll becomes due wins.
    apply_reset(2'd0, 2'd0);
    p0 = n_poll;
    for (int c = 0; c < PC + 1; c++) step();
    req_addr = {3{48'h0000_0000_A000}}; req_we = '0; req_valid = 3'b001;
    step();
    req_valid = '0;
    chk("race_ready", 64'(req_ready), 64'h1);
    chk("race_req_addr", 64'({mst_req, mst_addr}), 64'({1'b1, 48'h0000_0000_A000}));
    chk("race_no_poll_yet", 64'(n_poll - p0), 64'h0);
    r0 = rsp_cnt[0];
    for (int c = 0; c < 10 && rsp_cnt[0] == r0; c++) step();
    chk("race_rsp", 64'(rsp_cnt[0] - r0), 64'h1);
    g = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      g++;
      seen = mst_req && mst_addr == EOC;
    end
    chk("race_poll_seen", 64'(seen), 64'h1);
    chk("race_poll_gap", 64'(g >= PC && g <= PC + 2), 64'h1);

    // Reset while a request waits for grant; late rvalid must be dropped.
    model_en = 1'b0;
    apply_reset(2'd0, 2'd0);
    req_addr = {3{48'h0000_0000_B000}}; req_we = 3'b111; req_wdata = {3{32'h5555_AAAA}};
    req_valid = 3'b001;
    for (int c = 0; c < 10 && !mst_req; c++) begin
      step();
      req_valid = req_valid & ~req_ready;
    end
    req_valid = '0;
    step();
    step();
    chk("abort_req_held", 64'({mst_req, mst_addr}), 64'({1'b1, 48'h0000_0000_B000}));
    rst_n = 1'b0;
    step();
    check_reset("abort");
    r0 = rsp_total();
    rst_n = 1'b1;
    man_rvalid = 1'b1;
    man_rdata = 32'h1;
    step();
    step();
    man_rvalid = 1'b0;
    for (int c = 0; c < 8; c++) step();
    chk("abort_late_rvalid", 64'(rsp_total() - r0), 64'h0);
    model_en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/carfield_preload_ctrl.md
CARFIELD_PRELOAD_CTRL -- requirements
Module: carfield_preload_ctrl

Interface
REQ-001 Parameter AddrWidth, default 48, width of all request/master addresses.
REQ-002 Parameter DataWidth, default 32, width of write/read data.
REQ-003 Parameter EocAddr, default 48'h0300_0008, address of the end-of-computation scratch register.
REQ-004 Parameter PollCycles, default 1024, idle cycles between EOC polls (minimum 1).
REQ-005 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_ni  in  1  reset, synchronous and active-low.
REQ-007 boot_mode_i  in  2  boot mode pins: 0 idle/preload, 1 SD (unsupported), 2..3 autonomous.
REQ-008 preload_mode_i  in  2  preload source: 0 JTAG, 1 serial link, 2 UART, 3 reserved.
REQ-009 req_valid_i  in  3  per-requester request valid (index 0 JTAG, 1 slink, 2 UART).
REQ-010 req_ready_o  out  3  per-requester request accepted.
REQ-011 req_addr_i / req_we_i / req_wdata_i  in  3xAddrWidth / 3 / 3xDataWidth  per-requester payload.
REQ-012 rsp_valid_o  out  3  one-cycle response pulse to the serviced requester.
REQ-013 rsp_rdata_o / rsp_err_o  out  DataWidth / 1  response data and error, shared, valid with rsp_valid_o.
REQ-014 mst_req_o, mst_addr_o, mst_we_o, mst_wdata_o  out  1 / AddrWidth / 1 / DataWidth  downstream request.
REQ-015 mst_gnt_i, mst_rvalid_i, mst_rdata_i, mst_err_i  in  1 / 1 / DataWidth / 1  downstream grant and response.
REQ-016 eoc_o  out  1  sticky end-of-computation flag.
REQ-017 exit_code_o  out  DataWidth-1  exit code, rdata[DataWidth-1:1] of the terminating poll.
REQ-018 cfg_err_o  out  1  sticky unsupported boot/preload configuration.

Function
REQ-019 First cycle after reset release the block SHALL latch boot_mode_i and preload_mode_i; later changes are ignored until the next reset.
REQ-020 Eligible set: boot mode 0 -> only requester preload_mode_q; boot mode 2/3 -> only requester 0; boot mode 1 or preload mode 3 (with boot 0) -> none, cfg_err_o=1 from the cycle after latching.
REQ-021 Non-eligible requesters SHALL never see req_ready_o or rsp_valid_o asserted.
REQ-022 FSM states: LATCH, IDLE, REQ, RSP, POLL_REQ, POLL_RSP, DONE; exactly one downstream transaction outstanding.
REQ-023 LATCH -> IDLE unconditionally after one cycle.
REQ-024 IDLE: eligible req_valid_i high -> req_ready_o pulses one cycle, payload registered, -> REQ; requester has priority over a due poll in the same cycle.
REQ-025 REQ: mst_req_o=1 with registered payload, held stable until mst_gnt_i; on gnt -> RSP.
REQ-026 RSP: on mst_rvalid_i, rsp_valid_o pulses next cycle with registered rdata/err to the serviced index; -> IDLE. mst_rvalid_i in the grant cycle SHALL be accepted.
REQ-027 Poll counter counts IDLE cycles, resets to 0 on leaving IDLE; at PollCycles and no eligible request -> POLL_REQ.
REQ-028 POLL_REQ issues a read (we=0) to EocAddr, held until gnt -> POLL_RSP.
REQ-029 POLL_RSP: rvalid with rdata[0]=1 and err=0 -> eoc_o=1, exit_code_o=rdata[DataWidth-1:1], -> DONE; otherwise -> IDLE, no requester response.
REQ-030 DONE: no further polls; eligible requests still serviced via REQ/RSP (returning to DONE).
REQ-031 Polling SHALL occur in all boot modes, including with cfg_err_o set.
REQ-032 Poll counter SHALL saturate, never wrap.

Reset
REQ-033 While rst_ni=0 at a clock edge: state LATCH, counter 0, req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, mst_req_o=0, mst_addr_o=0, mst_we_o=0, mst_wdata_o=0, eoc_o=0, exit_code_o=0, cfg_err_o=0.
REQ-034 Reset mid-transaction SHALL abandon it; a late mst_rvalid_i after reset SHALL be ignored.

Verification
REQ-035 boot=0, pre=1, slink writes 0xDEAD_BEEF to 0x8000_0000, gnt after 3 cycles -> one mst write, rsp_valid_o[1] pulse, req_ready_o[0]/[2] never high.
REQ-036 boot=2, UART and JTAG request same cycle -> only JTAG serviced; UART stalled indefinitely.
REQ-037 PollCycles=4, memory returns 0 then 0x0000_0007 -> two reads to EocAddr, eoc_o=1, exit_code_o=3.
REQ-038 boot=1 -> cfg_err_o=1 two cycles after reset release, no requester serviced, polling continues.
REQ-039 Request valid in same cycle poll becomes due -> requester transaction first, poll follows PollCycles idle cycles later.
REQ-040 rst_ni low during REQ with mst_gnt_i pending -> all outputs at reset values next cycle; later rvalid produces no rsp_valid_o.
